// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential non-restoring divider.
package div_pkg;

    localparam int DIV_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// One non-restoring iteration: shift the partial remainder left by one and
// add or subtract the divisor depending on the sign of the incoming remainder.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_bit_in,
    input  logic [WIDTH-1:0] i_dsr,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_dsr_ext;

    // The shifted value may wrap in WIDTH+1 bits; the add/sub result still
    // lands in range because |remainder| < divisor after every step.
    assign w_shift   = {i_rem[WIDTH-1:0], i_bit_in};
    assign w_dsr_ext = {1'b0, i_dsr};
    assign o_rem     = i_rem[WIDTH] ? (w_shift + w_dsr_ext) : (w_shift - w_dsr_ext);
    assign o_q_bit   = ~o_rem[WIDTH];

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential signed/unsigned divider: one non-restoring step per cycle,
// followed by a single remainder/sign correction cycle.
//
//   state | meaning
//   IDLE  | ready for operands
//   CALC  | WIDTH shift/add-sub iterations, down-counter tracks remaining steps
//   FIX   | remainder correction and sign fix-up of quotient/remainder
//   DONE  | result valid, held until out_ready
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH     = DIV_WIDTH_DEF,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int              CW      = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       r_state;
    div_state_t       w_state_nxt;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dsr;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;
    logic             r_ovf;

    logic             w_accept;
    logic             w_sgn;
    logic             w_dvd_neg;
    logic             w_dsr_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic             w_div_zero;
    logic             w_ovf;
    logic [WIDTH:0]   w_step_rem;
    logic             w_step_q;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_sgn      = SIGNED_EN && signed_mode;
    assign w_dvd_neg  = w_sgn && dividend[WIDTH-1];
    assign w_dsr_neg  = w_sgn && divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
    assign w_dsr_mag  = w_dsr_neg ? -divisor : divisor;
    assign w_div_zero = (divisor == '0);
    assign w_ovf      = w_sgn && (dividend == MIN_VAL) && (divisor == '1);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem    (r_rem),
        .i_bit_in (r_quo[WIDTH-1]),
        .i_dsr    (r_dsr),
        .o_rem    (w_step_rem),
        .o_q_bit  (w_step_q)
    );

    // A corrected remainder is non-negative and below the divisor, so the low
    // WIDTH bits of the sum carry the full magnitude.
    assign w_rem_mag = r_rem[WIDTH-1:0] + (r_rem[WIDTH] ? r_dsr : '0);
    assign w_quo_fix = r_q_neg ? -r_quo : r_quo;
    assign w_rem_fix = r_r_neg ? -w_rem_mag : w_rem_mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_div_zero || w_ovf) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dsr       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= CW'(WIDTH);
                        r_rem   <= '0;
                        r_quo   <= w_dvd_mag;
                        r_dsr   <= w_dsr_mag;
                        r_q_neg <= w_dvd_neg ^ w_dsr_neg;
                        r_r_neg <= w_dvd_neg;
                        r_dbz   <= w_div_zero;
                        r_ovf   <= !w_div_zero && w_ovf;
                        if (w_div_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                        end else if (w_ovf) begin
                            r_quotient  <= MIN_VAL;
                            r_remainder <= '0;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_step_q};
                    r_cnt <= r_cnt - CW'(1);
                end
                FIX: begin
                    r_quotient  <= w_quo_fix;
                    r_remainder <= w_rem_fix;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Directed vector bench for seq_divider at WIDTH=16, with hand-written
// sequences for output hold and mid-calculation reset.
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] dvd;
        logic [15:0] dsr;
        logic        sgn;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    seq_divider #(
        .WIDTH     (16),
        .SIGNED_EN (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int hold);
        int          lat;
        logic [15:0] q_held;
        logic [15:0] r_held;
        @(negedge clk);
        dividend    = v.dvd;
        divisor     = v.dsr;
        signed_mode = v.sgn;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        // keep offering junk while busy; none of it may be taken
        dividend    = 16'($urandom);
        divisor     = 16'($urandom);
        signed_mode = 1'($urandom);
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, v.lat);
        chk("quotient", {16'd0, quotient}, {16'd0, v.q});
        chk("remainder", {16'd0, remainder}, {16'd0, v.r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, v.dbz});
        chk("overflow", {31'd0, overflow}, {31'd0, v.ovf});
        q_held = quotient;
        r_held = remainder;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_quotient", {16'd0, quotient}, {16'd0, v.q});
            chk("hold_remainder", {16'd0, remainder}, {16'd0, v.r});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        dividend    = '0;
        divisor     = '0;
        signed_mode = 1'b0;
        out_ready   = 1'b0;

        //             dvd       dsr       sgn   q         r         dbz   ovf   lat
        vecs.push_back('{16'd100,  16'd7,    1'b0, 16'h000E, 16'h0002, 1'b0, 1'b0, 18});
        vecs.push_back('{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 18});
        vecs.push_back('{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 18});
        vecs.push_back('{16'd1234, 16'h0000, 1'b0, 16'hFFFF, 16'h04D2, 1'b1, 1'b0, 1});
        vecs.push_back('{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 1});
        vecs.push_back('{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, 18});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 18});
        vecs.push_back('{16'h0005, 16'h0009, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b0, 18});
        vecs.push_back('{16'hFF9C, 16'hFFF9, 1'b1, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 18});
        vecs.push_back('{16'h8000, 16'h0002, 1'b1, 16'hC000, 16'h0000, 1'b0, 1'b0, 18});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1});
        vecs.push_back('{16'hABCD, 16'h0100, 1'b0, 16'h00AB, 16'h00CD, 1'b0, 1'b0, 18});
        vecs.push_back('{16'h7FFF, 16'h8000, 1'b1, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 18});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {16'd0, remainder}, 32'd0);
        chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i], 0);
        end

        // result held while the consumer stalls for five cycles
        run_op(vecs[0], 5);

        // reset in the middle of the iteration phase
        @(negedge clk);
        dividend    = 16'h1234;
        divisor     = 16'h0005;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_quotient", {16'd0, quotient}, 32'd0);
        chk("abort_remainder", {16'd0, remainder}, 32'd0);
        chk("abort_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        run_op('{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 18}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_seq_divider
